// File: rtl/multi_sub_pkg.sv
// Shared definitions for the iterative multiply-add/subtract unit:
// FSM state encoding and status-word bit positions.
package multi_sub_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StAdj  = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam int unsigned ST_Z = 0;
   localparam int unsigned ST_C = 1;
   localparam int unsigned ST_B = 2;
   localparam int unsigned ST_N = 3;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiplier step: accumulates the multiplicand, shifted by bit position,
// for every set bit in the current multiplier slice.
module mul_step #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic [2*WIDTH-1:0]        acc,
   input  logic [2*WIDTH-1:0]        mcand,
   input  logic [BITS_PER_CYCLE-1:0] slice,
   output logic [2*WIDTH-1:0]        acc_next
);

   always_comb begin
      acc_next = acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (slice[i]) begin
            acc_next = acc_next + (mcand << i);
         end
      end
   end

endmodule

// File: rtl/multi_sub_seq.sv
// Multi-cycle x*y -/+ z unit with start/busy/done handshake and {N,B,C,Z} status.
// IDLE -> MUL (WIDTH/BITS_PER_CYCLE cycles) -> ADJ -> DONE; DONE may accept a new start.
module multi_sub_seq
   import multi_sub_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       st
);

   localparam int unsigned ITER  = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = $clog2(ITER + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               op_q;
   logic [WIDTH-1:0]   z_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [PW-1:0]      mcand_q;
   logic [PW-1:0]      acc_q;
   logic [PW-1:0]      acc_step;
   logic [PW:0]        r_ext;
   logic               borrow;
   logic               carry;
   logic [WIDTH-1:0]   res_new;
   logic [3:0]         st_new;

   mul_step #(
      .WIDTH         (WIDTH),
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_mul_step (
      .acc     (acc_q),
      .mcand   (mcand_q),
      .slice   (mplier_q[BITS_PER_CYCLE-1:0]),
      .acc_next(acc_step)
   );

   // Adjust at 2*WIDTH+1 bits so the product's overflow and the borrow are both visible.
   always_comb begin
      r_ext   = op_q ? ({1'b0, acc_q} + (PW+1)'(z_q)) : ({1'b0, acc_q} - (PW+1)'(z_q));
      borrow  = !op_q && (acc_q < PW'(z_q));
      carry   = !borrow && (r_ext[PW:WIDTH] != '0);
      res_new = r_ext[WIDTH-1:0];
      st_new       = '0;
      st_new[ST_Z] = (res_new == '0);
      st_new[ST_C] = carry;
      st_new[ST_B] = borrow;
      st_new[ST_N] = res_new[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         z_q      <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         res      <= '0;
         st       <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done <= 1'b0;
               if (start) begin
                  op_q     <= op;
                  z_q      <= z;
                  mcand_q  <= PW'(x);
                  mplier_q <= y;
                  acc_q    <= '0;
                  cnt_q    <= CNT_W'(ITER);
                  busy     <= 1'b1;
                  state_q  <= StMul;
               end else begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StMul: begin
               acc_q    <= acc_step;
               mcand_q  <= mcand_q << BITS_PER_CYCLE;
               mplier_q <= mplier_q >> BITS_PER_CYCLE;
               cnt_q    <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= StAdj;
               end
            end
            StAdj: begin
               res     <= res_new;
               st      <= st_new;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= StDone;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_sub_seq.sv
// Bench for multi_sub_seq: two instances (1 and 2 bits per cycle) checked every cycle
// against an arithmetic reference model, plus directed literal cases.
module tb_multi_sub_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s [2];
   logic       op_s    [2];
   logic [7:0] x_s     [2];
   logic [7:0] y_s     [2];
   logic [7:0] z_s     [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic [7:0] res_s   [2];
   logic [3:0] st_s    [2];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   multi_sub_seq #(
      .WIDTH         (8),
      .BITS_PER_CYCLE(1)
   ) dut0 (
      .clk  (clk),
      .rst  (rst),
      .start(start_s[0]),
      .op   (op_s[0]),
      .x    (x_s[0]),
      .y    (y_s[0]),
      .z    (z_s[0]),
      .busy (busy_s[0]),
      .done (done_s[0]),
      .res  (res_s[0]),
      .st   (st_s[0])
   );

   multi_sub_seq #(
      .WIDTH         (8),
      .BITS_PER_CYCLE(2)
   ) dut1 (
      .clk  (clk),
      .rst  (rst),
      .start(start_s[1]),
      .op   (op_s[1]),
      .x    (x_s[1]),
      .y    (y_s[1]),
      .z    (z_s[1]),
      .busy (busy_s[1]),
      .done (done_s[1]),
      .res  (res_s[1]),
      .st   (st_s[1])
   );

   task automatic chk(input string name, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[dut%0d]: got %0h expected %0h (t=%0t)", name, i, act, exp, $time);
      end
   endtask

   // Reference model: operation accepted when idle, result appears WIDTH/bpc+2 cycles later.
   bit         m_valid = 1'b0;
   bit         m_act     [2];
   int         m_done_at [2];
   bit         m_op      [2];
   logic [7:0] m_x [2];
   logic [7:0] m_y [2];
   logic [7:0] m_z [2];
   bit         e_busy [2];
   bit         e_done [2];
   logic [7:0] e_res  [2];
   logic [3:0] e_st   [2];
   int         cyc = 0;

   function automatic int lat_of(input int i);
      return 8 / ((i == 0) ? 1 : 2) + 2;
   endfunction

   always @(posedge clk) begin
      longint p, r;
      bit     b, c;
      logic [7:0] rr;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_act[i]  = 1'b0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_res[i]  = 8'h00;
            e_st[i]   = 4'h0;
         end else begin
            e_done[i] = 1'b0;
            if (m_act[i] && (cyc + 1 == m_done_at[i])) begin
               p  = longint'(m_x[i]) * longint'(m_y[i]);
               r  = m_op[i] ? p + longint'(m_z[i]) : p - longint'(m_z[i]);
               b  = !m_op[i] && (p < longint'(m_z[i]));
               c  = !b && (r >= 256);
               rr = 8'(r);
               e_res[i]  = rr;
               e_st[i]   = {rr[7], b, c, (rr == 8'h00)};
               e_done[i] = 1'b1;
               e_busy[i] = 1'b0;
               m_act[i]  = 1'b0;
            end else if (!m_act[i] && start_s[i]) begin
               m_op[i]      = op_s[i];
               m_x[i]       = x_s[i];
               m_y[i]       = y_s[i];
               m_z[i]       = z_s[i];
               m_act[i]     = 1'b1;
               m_done_at[i] = cyc + lat_of(i);
               e_busy[i]    = 1'b1;
            end
         end
      end
      if (rst) m_valid = 1'b1;
      cyc++;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < 2; i++) begin
            chk("busy", i, 32'(busy_s[i]), 32'(e_busy[i]));
            chk("done", i, 32'(done_s[i]), 32'(e_done[i]));
            chk("res",  i, 32'(res_s[i]),  32'(e_res[i]));
            chk("st",   i, 32'(st_s[i]),   32'(e_st[i]));
         end
      end
   end

   // Drives start for one cycle, then scrambles operands to prove they were captured.
   task automatic issue(input int i, input bit op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] z);
      op_s[i]    = op;
      x_s[i]     = x;
      y_s[i]     = y;
      z_s[i]     = z;
      start_s[i] = 1'b1;
      @(posedge clk);
      #1;
      start_s[i] = 1'b0;
      op_s[i]    = 1'($urandom);
      x_s[i]     = 8'($urandom);
      y_s[i]     = 8'($urandom);
      z_s[i]     = 8'($urandom);
   endtask

   task automatic wait_done(input int i, input string name, input logic [7:0] xr,
                            input logic [3:0] xs, input int xl);
      int lat = 0;
      bit seen = 1'b0;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(negedge clk);
         if (done_s[i]) begin
            seen = 1'b1;
            lat  = n;
         end
      end
      chk({name, "_lat"}, i, 32'(lat), 32'(xl));
      chk({name, "_res"}, i, 32'(res_s[i]), 32'(xr));
      chk({name, "_st"},  i, 32'(st_s[i]), 32'(xs));
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 4))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'h01;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int pulses;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         op_s[i]    = 1'b0;
         x_s[i]     = 8'h00;
         y_s[i]     = 8'h00;
         z_s[i]     = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 0, 32'(busy_s[0]), 32'd0);
      chk("rst_res",  0, 32'(res_s[0]),  32'd0);
      chk("rst_st",   0, 32'(st_s[0]),   32'd0);
      rst = 1'b0;

      @(posedge clk); #1; issue(0, 1'b0, 8'h01, 8'h01, 8'h02); wait_done(0, "t1",  8'hFF, 4'hC, 10);
      @(posedge clk); #1; issue(0, 1'b0, 8'h00, 8'h00, 8'h00); wait_done(0, "t2a", 8'h00, 4'h1, 10);
      @(posedge clk); #1; issue(0, 1'b0, 8'h00, 8'h00, 8'h01); wait_done(0, "t2b", 8'hFF, 4'hC, 10);
      @(posedge clk); #1; issue(0, 1'b0, 8'h03, 8'h55, 8'h0C); wait_done(0, "t3a", 8'hF3, 4'h8, 10);
      @(posedge clk); #1; issue(0, 1'b0, 8'h03, 8'h56, 8'h01); wait_done(0, "t3b", 8'h01, 4'h2, 10);
      @(posedge clk); #1; issue(0, 1'b1, 8'hFF, 8'h01, 8'h01); wait_done(0, "t4",  8'h00, 4'h3, 10);
      @(posedge clk); #1; issue(1, 1'b1, 8'hFF, 8'h01, 8'h01); wait_done(1, "t4w", 8'h00, 4'h3, 6);

      // Start mid-operation is ignored; start in the DONE cycle is accepted.
      @(posedge clk); #1; issue(0, 1'b0, 8'h03, 8'h55, 8'h0C);
      @(posedge clk); #1;
      @(posedge clk); #1;
      issue(0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
      wait_done(0, "t5a", 8'hF3, 4'h8, 7);
      issue(0, 1'b1, 8'hFF, 8'h01, 8'h01);
      wait_done(0, "t5b", 8'h00, 4'h3, 10);

      // Reset during the fourth MUL cycle aborts without a done pulse.
      @(posedge clk); #1; issue(0, 1'b0, 8'h03, 8'h56, 8'h01);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_busy", 0, 32'(busy_s[0]), 32'd0);
      chk("t6_done", 0, 32'(done_s[0]), 32'd0);
      chk("t6_res",  0, 32'(res_s[0]),  32'd0);
      chk("t6_st",   0, 32'(st_s[0]),   32'd0);
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_s[0]) pulses++;
      end
      chk("t6_nodone", 0, 32'(pulses), 32'd0);
      @(posedge clk); #1; issue(0, 1'b0, 8'h03, 8'h56, 8'h01); wait_done(0, "t6c", 8'h01, 4'h2, 10);

      // Random traffic, including starts while busy, rare resets and rst+start together.
      repeat (4000) begin
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++) begin
            start_s[i] = ($urandom_range(0, 2) == 0);
            op_s[i]    = 1'($urandom);
            x_s[i]     = pick();
            y_s[i]     = pick();
            z_s[i]     = pick();
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) start_s[i] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
